// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IR opcodes, IR capture pattern,
// TAP state encodings and the data-register select type.
package jtag_pkg;

   localparam logic [3:0] OPC_IDCODE = 4'h1;
   localparam logic [3:0] OPC_USER   = 4'h2;
   localparam logic [3:0] OPC_BYPASS = 4'hF;

   localparam logic [1:0] IR_CAPTURE = 2'b01;

   typedef enum logic [3:0] {
      TEST_LOGIC_RESET,
      RUN_TEST_IDLE,
      SELECT_DR_SCAN,
      CAPTURE_DR,
      SHIFT_DR,
      EXIT1_DR,
      PAUSE_DR,
      EXIT2_DR,
      UPDATE_DR,
      SELECT_IR_SCAN,
      CAPTURE_IR,
      SHIFT_IR,
      EXIT1_IR,
      PAUSE_IR,
      EXIT2_IR,
      UPDATE_IR
   } tap_state_e;

   typedef enum logic [1:0] {
      DR_BYPASS,
      DR_IDCODE,
      DR_USER
   } dr_sel_e;

endpackage

// File: rtl/jtag_shift_reg.sv
// Capture/shift register, LSB shifted out first, TDI
// enters at the MSB. Capture wins over shift.
module jtag_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             capture_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] load_i,
   input  logic             tdi_i,
   output logic [WIDTH-1:0] q_o,
   output logic             so_o
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   // Next value: parallel capture, else shift right
   always_comb begin
      sr_d = sr_q;
      if (capture_i) begin
         sr_d = load_i;
      end else if (shift_i) begin
         sr_d = {tdi_i, sr_q[WIDTH-1:1]};
      end
   end

   // Register with synchronous clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign q_o  = sr_q;
   assign so_o = sr_q[0];

endmodule

// File: rtl/jtag_tap_registers.sv
// IR and DR bank behind the TAP FSM: IDCODE, BYPASS and,
// with JTAG_USER_REG_EN defined, a USER data register.
module jtag_tap_registers
   import jtag_pkg::*;
#(
   parameter int          IR_WIDTH   = 4,
   parameter logic [31:0] IDCODE     = 32'h0000_FAF1,
   parameter int          USER_WIDTH = 8
) (
   input  logic                  tck,
   input  logic                  trst,
   input  logic                  tdi,
   input  logic                  tlr,
   input  logic                  capture_ir,
   input  logic                  shift_ir,
   input  logic                  update_ir,
   input  logic                  capture_dr,
   input  logic                  shift_dr,
   input  logic                  update_dr,
   output logic                  tdo,
   output logic [IR_WIDTH-1:0]   ir_active,
   output logic [USER_WIDTH-1:0] user_data,
   output logic                  user_valid
);

`ifdef JTAG_USER_REG_EN
   localparam bit USER_EN = 1'b1;
`else
   localparam bit USER_EN = 1'b0;
`endif

   logic rst;
   logic ir_any;
   logic ir_upd;
   logic ir_cap;
   logic ir_sh;
   logic dr_en;
   logic dr_upd;
   logic dr_cap;
   logic dr_sh;

   // trst > tlr > update > capture > shift; IR beats DR
   assign rst    = trst | tlr;
   assign ir_any = capture_ir | shift_ir | update_ir;
   assign ir_upd = !rst & update_ir;
   assign ir_cap = !rst & capture_ir & !update_ir;
   assign ir_sh  = !rst & shift_ir & !update_ir
                 & !capture_ir;
   assign dr_en  = !rst & !ir_any;
   assign dr_upd = dr_en & update_dr;
   assign dr_cap = dr_en & capture_dr & !update_dr;
   assign dr_sh  = dr_en & shift_dr & !update_dr
                 & !capture_dr;

   logic [IR_WIDTH-1:0] ir_sr;
   logic                ir_so;
   logic [IR_WIDTH-1:0] ir_active_q;
   logic [IR_WIDTH-1:0] ir_active_d;

   jtag_shift_reg #(.WIDTH(IR_WIDTH)) u_ir (
      .clk_i     (tck),
      .rst_i     (rst),
      .capture_i (ir_cap),
      .shift_i   (ir_sh),
      .load_i    (IR_WIDTH'(IR_CAPTURE)),
      .tdi_i     (tdi),
      .q_o       (ir_sr),
      .so_o      (ir_so)
   );

   // Latched instruction moves only on update_ir
   always_comb begin
      ir_active_d = ir_upd ? ir_sr : ir_active_q;
   end

   // Instruction register, resets to IDCODE
   always_ff @(posedge tck) begin
      if (rst) begin
         ir_active_q <= IR_WIDTH'(OPC_IDCODE);
      end else begin
         ir_active_q <= ir_active_d;
      end
   end

   assign ir_active = ir_active_q;

   dr_sel_e sel;

   // Decode the latched opcode; unknown ones mean BYPASS
   always_comb begin
      sel = DR_BYPASS;
      if (ir_active_q == IR_WIDTH'(OPC_IDCODE)) begin
         sel = DR_IDCODE;
      end else if (USER_EN &&
                   ir_active_q == IR_WIDTH'(OPC_USER)) begin
         sel = DR_USER;
      end
   end

   logic [31:0] idcode_q_unused;
   logic        id_so;

   jtag_shift_reg #(.WIDTH(32)) u_idcode (
      .clk_i     (tck),
      .rst_i     (rst),
      .capture_i (dr_cap & (sel == DR_IDCODE)),
      .shift_i   (dr_sh & (sel == DR_IDCODE)),
      .load_i    (IDCODE),
      .tdi_i     (tdi),
      .q_o       (idcode_q_unused),
      .so_o      (id_so)
   );

   logic byp_q;
   logic byp_d;

   // Bypass flop: cleared on capture, follows tdi on shift
   always_comb begin
      byp_d = byp_q;
      if (sel == DR_BYPASS) begin
         if (dr_cap) begin
            byp_d = 1'b0;
         end else if (dr_sh) begin
            byp_d = tdi;
         end
      end
   end

   // Bypass register
   always_ff @(posedge tck) begin
      if (rst) begin
         byp_q <= 1'b0;
      end else begin
         byp_q <= byp_d;
      end
   end

   logic usr_so;

`ifdef JTAG_USER_REG_EN
   logic [USER_WIDTH-1:0] usr_sr;
   logic [USER_WIDTH-1:0] user_data_q;
   logic [USER_WIDTH-1:0] user_data_d;
   logic                  user_valid_q;
   logic                  user_valid_d;

   jtag_shift_reg #(.WIDTH(USER_WIDTH)) u_user (
      .clk_i     (tck),
      .rst_i     (rst),
      .capture_i (dr_cap & (sel == DR_USER)),
      .shift_i   (dr_sh & (sel == DR_USER)),
      .load_i    (user_data_q),
      .tdi_i     (tdi),
      .q_o       (usr_sr),
      .so_o      (usr_so)
   );

   // Publish the shifted USER value, pulse valid once
   always_comb begin
      user_data_d  = user_data_q;
      user_valid_d = 1'b0;
      if (dr_upd && sel == DR_USER) begin
         user_data_d  = usr_sr;
         user_valid_d = 1'b1;
      end
   end

   // USER parallel output registers
   always_ff @(posedge tck) begin
      if (rst) begin
         user_data_q  <= '0;
         user_valid_q <= 1'b0;
      end else begin
         user_data_q  <= user_data_d;
         user_valid_q <= user_valid_d;
      end
   end

   assign user_data  = user_data_q;
   assign user_valid = user_valid_q;
`else
   assign usr_so     = 1'b0;
   assign user_data  = '0;
   assign user_valid = 1'b0;
`endif

   // TDO shows the LSB of whichever register is shifting
   always_comb begin
      tdo = 1'b0;
      if (ir_sh) begin
         tdo = ir_so;
      end else if (dr_sh) begin
         unique case (sel)
            DR_IDCODE: tdo = id_so;
            DR_USER:   tdo = usr_so;
            default:   tdo = byp_q;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_tap_registers.sv
// Scoreboard bench for jtag_tap_registers: directed
// scans plus random strobes against a behavioural model.
module tb_jtag_tap_registers;

`ifdef JTAG_USER_REG_EN
   localparam bit UEN = 1'b1;
`else
   localparam bit UEN = 1'b0;
`endif

   localparam logic [31:0] IDC = 32'h0000_FAF1;

   localparam logic [7:0] S_IDLE = 8'h00;
   localparam logic [7:0] S_TRST = 8'h80;
   localparam logic [7:0] S_TLR  = 8'h40;
   localparam logic [7:0] S_CIR  = 8'h20;
   localparam logic [7:0] S_SIR  = 8'h10;
   localparam logic [7:0] S_UIR  = 8'h08;
   localparam logic [7:0] S_CDR  = 8'h04;
   localparam logic [7:0] S_SDR  = 8'h02;
   localparam logic [7:0] S_UDR  = 8'h01;

   logic       tck = 1'b0;
   logic       trst = 1'b0;
   logic       tdi = 1'b0;
   logic       tlr = 1'b0;
   logic       capture_ir = 1'b0;
   logic       shift_ir = 1'b0;
   logic       update_ir = 1'b0;
   logic       capture_dr = 1'b0;
   logic       shift_dr = 1'b0;
   logic       update_dr = 1'b0;
   logic       tdo;
   logic [3:0] ir_active;
   logic [7:0] user_data;
   logic       user_valid;

   jtag_tap_registers dut (
      .tck        (tck),
      .trst       (trst),
      .tdi        (tdi),
      .tlr        (tlr),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .tdo        (tdo),
      .ir_active  (ir_active),
      .user_data  (user_data),
      .user_valid (user_valid)
   );

   always #5 tck = ~tck;

   typedef struct {
      logic       known;
      logic       tdo;
      logic [3:0] ir;
      logic [7:0] ud;
      logic       uv;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   logic        m_known = 1'b0;
   logic [3:0]  m_ir_act;
   logic [3:0]  m_ir_sr;
   logic [31:0] m_id;
   logic        m_byp;
   logic [7:0]  m_usr;
   logic [7:0]  m_ud;
   logic        m_uv;

   task automatic cmp(input string n,
                      input logic [31:0] a,
                      input logic [31:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t",
                  n, a, x, $time);
      end
   endtask

   // 0 = bypass, 1 = idcode, 2 = user
   function automatic int m_sel();
      if (m_ir_act == 4'h1) return 1;
      if (UEN && m_ir_act == 4'h2) return 2;
      return 0;
   endfunction

   task automatic step(input logic [7:0] s,
                       input logic d);
      exp_t e;
      logic rst, irany;
      int   sl;
      @(posedge tck);
      #1;
      {trst, tlr, capture_ir, shift_ir, update_ir,
       capture_dr, shift_dr, update_dr} = s;
      tdi = d;
      rst   = s[7] | s[6];
      irany = s[5] | s[4] | s[3];
      sl    = m_sel();
      e.known = m_known;
      e.ir    = m_ir_act;
      e.ud    = m_ud;
      e.uv    = m_uv;
      e.tdo   = 1'b0;
      if (!rst) begin
         if (s[4] && !s[5] && !s[3]) begin
            e.tdo = m_ir_sr[0];
         end else if (!irany && s[1] && !s[2] && !s[0]) begin
            if (sl == 1) e.tdo = m_id[0];
            else if (sl == 2) e.tdo = m_usr[0];
            else e.tdo = m_byp;
         end
      end
      q.push_back(e);
      if (rst) begin
         m_known  = 1'b1;
         m_ir_act = 4'h1;
         m_ir_sr  = '0;
         m_id     = '0;
         m_byp    = 1'b0;
         m_usr    = '0;
         m_ud     = '0;
         m_uv     = 1'b0;
      end else begin
         m_uv = 1'b0;
         if (irany) begin
            if (s[3]) m_ir_act = m_ir_sr;
            else if (s[5]) m_ir_sr = 4'h1;
            else m_ir_sr = (m_ir_sr >> 1) | (4'(d) << 3);
         end else if (s[0]) begin
            if (sl == 2) begin
               m_ud = m_usr;
               m_uv = 1'b1;
            end
         end else if (s[2]) begin
            if (sl == 1) m_id = IDC;
            else if (sl == 2) m_usr = m_ud;
            else m_byp = 1'b0;
         end else if (s[1]) begin
            if (sl == 1) m_id = (m_id >> 1) | (32'(d) << 31);
            else if (sl == 2) m_usr = (m_usr >> 1) | (8'(d) << 7);
            else m_byp = d;
         end
      end
   endtask

   task automatic ir_scan(input logic [3:0] op);
      step(S_CIR, 1'b0);
      for (int i = 0; i < 4; i++) step(S_SIR, op[i]);
      step(S_UIR, 1'b0);
   endtask

   // Monitor: one scoreboard entry per observed cycle
   always @(negedge tck) begin : mon
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.known) begin
            cmp("sb_tdo", 32'(tdo), 32'(e.tdo));
            cmp("sb_ir", 32'(ir_active), 32'(e.ir));
            cmp("sb_ud", 32'(user_data), 32'(e.ud));
            cmp("sb_uv", 32'(user_valid), 32'(e.uv));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : drv
      logic [31:0] got;
      logic [7:0]  pat;
      logic [7:0]  s;
      int          r;
      int          k;
      logic [3:0]  op;

      step(S_TRST, 1'b0);
      step(S_IDLE, 1'b0);
      @(negedge tck);
      cmp("rst_ir", 32'(ir_active), 32'h1);
      cmp("rst_tdo", 32'(tdo), 32'h0);
      cmp("rst_ud", 32'(user_data), 32'h0);
      cmp("rst_uv", 32'(user_valid), 32'h0);

      step(S_CDR, 1'b0);
      got = '0;
      for (int i = 0; i < 32; i++) begin
         step(S_SDR, 1'b0);
         @(negedge tck);
         got[i] = tdo;
      end
      cmp("idcode_out", got, IDC);

      step(S_CIR, 1'b0);
      got = '0;
      for (int i = 0; i < 4; i++) begin
         step(S_SIR, 1'b1);
         @(negedge tck);
         got[i] = tdo;
      end
      cmp("ir_cap_out", got, 32'h1);
      step(S_UIR, 1'b0);
      step(S_IDLE, 1'b0);
      @(negedge tck);
      cmp("ir_upd_f", 32'(ir_active), 32'hF);

      step(S_CDR, 1'b0);
      pat = 8'b1101;
      got = '0;
      for (int i = 0; i < 4; i++) begin
         step(S_SDR, pat[i]);
         @(negedge tck);
         got[i] = tdo;
      end
      cmp("bypass_out", got, 32'b1010);

      ir_scan(4'h2);
      step(S_CDR, 1'b0);
      pat = 8'hA5;
      got = '0;
      for (int i = 0; i < 8; i++) begin
         step(S_SDR, pat[i]);
         @(negedge tck);
         got[i] = tdo;
      end
      cmp("user_shift_out", got, UEN ? 32'h00 : 32'h4A);
      step(S_UDR, 1'b0);
      step(S_IDLE, 1'b0);
      @(negedge tck);
      cmp("user_data", 32'(user_data), UEN ? 32'hA5 : 32'h0);
      cmp("user_valid_hi", 32'(user_valid), 32'(UEN));
      step(S_IDLE, 1'b0);
      @(negedge tck);
      cmp("user_valid_lo", 32'(user_valid), 32'h0);
      cmp("user_data_hold", 32'(user_data),
          UEN ? 32'hA5 : 32'h0);

      ir_scan(4'hF);
      step(S_CIR, 1'b0);
      step(S_SIR, 1'b1);
      step(S_SIR, 1'b1);
      step(S_TRST, 1'b0);
      step(S_IDLE, 1'b0);
      @(negedge tck);
      cmp("midrst_ir", 32'(ir_active), 32'h1);
      cmp("midrst_uv", 32'(user_valid), 32'h0);
      got = '0;
      for (int i = 0; i < 4; i++) begin
         step(S_SIR, 1'b1);
         @(negedge tck);
         got[i] = tdo;
      end
      cmp("midrst_irsr", got, 32'h0);
      step(S_TLR, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            step(S_TRST, 1'b0);
         end else if (r < 4) begin
            step(S_TLR, 1'b0);
         end else if (r < 8) begin
            k = $urandom_range(0, 3);
            if (k == 0) op = 4'h1;
            else if (k == 1) op = 4'h2;
            else if (k == 2) op = 4'hF;
            else op = 4'($urandom_range(0, 15));
            ir_scan(op);
         end else if (r < 14) begin
            step(S_IDLE, 1'($urandom_range(0, 1)));
         end else if (r < 22) begin
            s = 8'($urandom_range(0, 63));
            step(s, 1'($urandom_range(0, 1)));
         end else begin
            k = $urandom_range(0, 9);
            if (k == 0) s = S_CIR;
            else if (k <= 3) s = S_SIR;
            else if (k == 4) s = S_UIR;
            else if (k == 5) s = S_CDR;
            else if (k <= 8) s = S_SDR;
            else s = S_UDR;
            step(s, 1'($urandom_range(0, 1)));
         end
      end

      step(S_IDLE, 1'b0);
      step(S_IDLE, 1'b0);
      @(negedge tck);
      @(negedge tck);
      cmp("sb_drain", 32'(q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
